// File: rtl/sa_tile_scheduler_if.sv
// Tile scheduler bus: command handshake, A/B SRAM read ports, array drive
// and result flags. The scheduler takes the master side.
interface sa_tile_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int K_MAX      = 256
);
    localparam int LEN_W  = $clog2(K_MAX + 1);
    localparam int ADDR_W = $clog2(K_MAX);

    logic                       start;
    logic                       cfg_mode;
    logic [LEN_W-1:0]           cfg_len;
    logic                       busy;
    logic                       done;
    logic                       a_rd_en;
    logic [ADDR_W-1:0]          a_rd_addr;
    logic [ROWS*DATA_WIDTH-1:0] a_rd_data;
    logic                       w_rd_en;
    logic [ADDR_W-1:0]          w_rd_addr;
    logic [COLS*DATA_WIDTH-1:0] w_rd_data;
    logic                       arr_load;
    logic                       arr_data_flow;
    logic [ROWS*DATA_WIDTH-1:0] arr_A;
    logic [COLS*DATA_WIDTH-1:0] arr_B;
    logic                       res_valid;
    logic [ADDR_W-1:0]          res_idx;
    logic [31:0]                perf_cycles;

    modport master (
        input  start, cfg_mode, cfg_len, a_rd_data, w_rd_data,
        output busy, done, a_rd_en, a_rd_addr, w_rd_en, w_rd_addr,
               arr_load, arr_data_flow, arr_A, arr_B,
               res_valid, res_idx, perf_cycles
    );

    modport slave (
        output start, cfg_mode, cfg_len, a_rd_data, w_rd_data,
        input  busy, done, a_rd_en, a_rd_addr, w_rd_en, w_rd_addr,
               arr_load, arr_data_flow, arr_A, arr_B,
               res_valid, res_idx, perf_cycles
    );
endinterface

// File: rtl/sa_tile_scheduler.sv
// Systolic-array tile scheduler: weight load (WS) or B streaming (OS),
// skewed A feed, drain, result flagging.
// Optional busy-cycle counter enabled by defining SA_SCHED_PERF_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | reading weight rows ROWS-1..0 into the array (WS only)
// FEED   | reading A vectors 0..len-1 (and B vectors in OS)
// DRAIN  | skew lines and array flushing, (ROWS+COLS)*PE_LAT cycles
// DONE   | one-cycle completion pulse
module sa_tile_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int K_MAX      = 256,
    parameter int PE_LAT     = 1
) (
    input logic               clk,
    input logic               rst,
    sa_tile_scheduler_if.master bus
);
    localparam int LEN_W     = $clog2(K_MAX + 1);
    localparam int ADDR_W    = $clog2(K_MAX);
    localparam int DRAIN_CYC = (ROWS + COLS) * PE_LAT;
    localparam int RES_LAT   = ROWS * PE_LAT;
    localparam int TMR_W     = $clog2(K_MAX + ROWS + DRAIN_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       mode_q, mode_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [LEN_W-1:0]           len_clamped;
    logic                       start_acc;
    logic                       a_vld_q, w_vld_q, load_q;
    logic [RES_LAT-1:0]         rv_q;
    logic                       res_valid_ws;
    logic [ADDR_W-1:0]          res_cnt_q;
    logic [ROWS*DATA_WIDTH-1:0] a_in, a_skew;
    logic [COLS*DATA_WIDTH-1:0] b_in, b_skew, ws_b;

    assign len_clamped = (bus.cfg_len > LEN_W'(K_MAX)) ? LEN_W'(K_MAX) : bus.cfg_len;
    assign start_acc   = (state_q == S_IDLE) && bus.start;

    // State register, latched configuration and the phase timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic; the timer counts down and each phase ends at zero.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        len_d   = len_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.cfg_mode;
                    len_d  = len_clamped;
                    if (bus.cfg_mode) begin
                        state_d = S_LOAD_W;
                        tmr_d   = TMR_W'(ROWS - 1);
                    end else if (len_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FEED;
                        tmr_d   = TMR_W'(len_clamped) - TMR_W'(1);
                        addr_d  = '0;
                    end
                end
            end
            S_LOAD_W: begin
                if (tmr_q == '0) begin
                    if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FEED;
                        tmr_d   = TMR_W'(len_q) - TMR_W'(1);
                        addr_d  = '0;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_FEED: begin
                addr_d = addr_q + ADDR_W'(1);
                if (tmr_q == '0) begin
                    state_d = S_DRAIN;
                    tmr_d   = TMR_W'(DRAIN_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DRAIN: begin
                if (tmr_q == '0) state_d = S_DONE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read-valid tracking (1-cycle SRAMs), load strobe and WS result timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q   <= 1'b0;
            w_vld_q   <= 1'b0;
            load_q    <= 1'b0;
            rv_q      <= '0;
            res_cnt_q <= '0;
        end else begin
            a_vld_q <= bus.a_rd_en;
            w_vld_q <= bus.w_rd_en;
            load_q  <= (state_q == S_LOAD_W);
            rv_q    <= RES_LAT'({rv_q, a_vld_q & mode_q});
            if (start_acc)         res_cnt_q <= '0;
            else if (res_valid_ws) res_cnt_q <= res_cnt_q + ADDR_W'(1);
        end
    end

    assign a_in = a_vld_q ? bus.a_rd_data : '0;
    assign b_in = (w_vld_q && !mode_q) ? bus.w_rd_data : '0;
    assign ws_b = (w_vld_q && mode_q) ? bus.w_rd_data : '0;

    // Lane r of A is delayed r cycles; lane 0 passes straight through.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        if (r == 0) begin : g_direct
            assign a_skew[DATA_WIDTH-1:0] = a_in[DATA_WIDTH-1:0];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_q [r];
            // Per-lane skew shift register, keeps shifting zeros when idle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= a_in[r*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < r; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign a_skew[r*DATA_WIDTH +: DATA_WIDTH] = dly_q[r-1];
        end
    end

    // Lane c of B (OS streaming) is delayed c cycles.
    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        if (c == 0) begin : g_direct
            assign b_skew[DATA_WIDTH-1:0] = b_in[DATA_WIDTH-1:0];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_q [c];
            // Per-lane skew shift register for streamed B.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= b_in[c*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < c; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign b_skew[c*DATA_WIDTH +: DATA_WIDTH] = dly_q[c-1];
        end
    end

    assign res_valid_ws = rv_q[RES_LAT-1];

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.a_rd_en       = (state_q == S_FEED);
    assign bus.a_rd_addr     = (state_q == S_FEED) ? addr_q : '0;
    assign bus.w_rd_en       = (state_q == S_LOAD_W) || ((state_q == S_FEED) && !mode_q);
    assign bus.w_rd_addr     = (state_q == S_LOAD_W) ? tmr_q[ADDR_W-1:0] :
                               ((state_q == S_FEED) && !mode_q) ? addr_q : '0;
    assign bus.arr_load      = load_q;
    assign bus.arr_data_flow = mode_q;
    assign bus.arr_A         = a_skew;
    assign bus.arr_B         = mode_q ? ws_b : b_skew;
    assign bus.res_valid     = res_valid_ws || ((state_q == S_DONE) && !mode_q);
    assign bus.res_idx       = res_valid_ws ? res_cnt_q : '0;

`ifdef SA_SCHED_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: clears on accepted start, saturates, holds when idle.
    always_ff @(posedge clk) begin
        if (rst)                                        perf_q <= '0;
        else if (start_acc)                             perf_q <= '0;
        else if ((state_q != S_IDLE) && (perf_q != '1)) perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif
endmodule
